// File: rtl/conv_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : conv_frame_encoder
//  Brief    : Rate-1/2, constraint-length-3 convolutional encoder that frames
//             FRAME_LEN input bits per start request. Input bits are taken
//             over a valid/ready handshake, and one 2-bit symbol is produced
//             per accepted bit through a single-entry output register with
//             valid/ready flow control.
//  Options  : CONV_TAIL_EN - when defined, two zero tail bits are appended
//             after each frame so that the shift state returns to 00.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_frame_encoder #(
    parameter int         FRAME_LEN = 32,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       sym_valid,
    output logic [1:0] sym,
    input  logic       sym_ready,
    output logic       busy,
    output logic       frame_done
);

    // The counter has to be able to hold FRAME_LEN itself, so it never wraps
    // inside a frame.
    localparam int             CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;             // s[1] = oldest bit, s[0] = newest
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tail_q, tail_d;       // set after the first tail bit
    logic [1:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             frame_done_q, frame_done_d;

    // Helper signals from the next-state process.
    logic             slot_free;            // output register can take a symbol
    logic             load;                 // a bit is shifted in this cycle
    logic             load_bit;             // value of that bit
    logic [2:0]       r_vec;                // {s[1], s[0], new bit}

    assign slot_free = !sym_valid_q || sym_ready;
    assign r_vec     = {s_q, load_bit};

    // State register and datapath registers; reset drops any pending symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_q          <= 2'b00;
            cnt_q        <= '0;
            tail_q       <= 1'b0;
            sym_q        <= 2'b00;
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            tail_q       <= tail_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic, input handshake and symbol generation.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        cnt_d        = cnt_q;
        tail_d       = tail_q;
        sym_d        = sym_q;
        sym_valid_d  = sym_valid_q;
        frame_done_d = 1'b0;
        in_ready     = 1'b0;
        load         = 1'b0;
        load_bit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // in_valid is deliberately not looked at while taking start.
                if (start) begin
                    state_d = ST_DATA;
                    s_d     = 2'b00;
                    cnt_d   = '0;
                    tail_d  = 1'b0;
                end
            end

            ST_DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    load     = 1'b1;
                    load_bit = in_bit;
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_IDX) begin
`ifdef CONV_TAIL_EN
                        state_d = ST_TAIL;
`else
                        state_d = ST_DRAIN;
`endif
                    end
                end
            end

            ST_TAIL: begin
                // Flush the shift state with two zero bits.
                if (slot_free) begin
                    load     = 1'b1;
                    load_bit = 1'b0;
                    tail_d   = 1'b1;
                    if (tail_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The last symbol leaves (or has left) the output register;
                // frame_done rises together with sym_valid falling, so the
                // two are never high in the same cycle.
                if (slot_free) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output register: a new load wins over a consume in the same cycle.
        if (load) begin
            sym_d       = {^(r_vec & G0), ^(r_vec & G1)};
            sym_valid_d = 1'b1;
            s_d         = {s_q[0], load_bit};
        end else if (sym_ready) begin
            sym_valid_d = 1'b0;
        end
    end

    assign sym        = sym_q;
    assign sym_valid  = sym_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_frame_encoder
//  Brief    : Self-checking bench for conv_frame_encoder. Random handshake
//             timing, expected symbols from a convolution reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_frame_encoder;

    localparam int         FL  = 16;
    localparam logic [2:0] TG0 = 3'b111;
    localparam logic [2:0] TG1 = 3'b101;
`ifdef CONV_TAIL_EN
    localparam int TAIL_BITS = 2;
`else
    localparam int TAIL_BITS = 0;
`endif
    localparam int NSYM = FL + TAIL_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic       sym_ready = 1'b0;
    logic       busy;
    logic       frame_done;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];

    conv_frame_encoder #(
        .FRAME_LEN (FL),
        .G0        (TG0),
        .G1        (TG1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .sym_ready  (sym_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Data bit k of the frame; zero before the frame and for tail positions.
    function automatic logic bit_at(input logic [FL-1:0] b, input int k);
        if (k < 0 || k >= FL) return 1'b0;
        return b[k];
    endfunction

    // Output symbol i is the convolution of bits i, i-1, i-2 with each generator.
    task automatic build_exp(input logic [FL-1:0] b);
        logic [2:0] r;
        exp_q.delete();
        for (int i = 0; i < NSYM; i++) begin
            r = {bit_at(b, i - 2), bit_at(b, i - 1), bit_at(b, i)};
            exp_q.push_back({^(r & TG0), ^(r & TG1)});
        end
    endtask

    task automatic run_frame(input logic [FL-1:0] b, input int rdy_pct, input int vld_pct,
                             input bit stall5, input int abort_at);
        int         idx, nsym, stall_left, cyc;
        bit         done, aborted, held, seen_first;
        logic [1:0] held_sym;
        build_exp(b);
        idx = 0; nsym = 0; stall_left = 0; cyc = 0;
        done = 0; aborted = 0; held = 0; seen_first = 0; held_sym = 2'b00;

        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_bit = 1'($urandom); sym_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
        @(posedge clk);

        while (!done && !aborted && cyc < 400) begin
            cyc++;
            @(negedge clk);
            start = (idx == 3);                    // must be ignored in DATA
            if (stall5 && sym_valid && !seen_first) begin
                seen_first = 1; stall_left = 5;
            end
            if (stall_left > 0) begin
                sym_ready = 1'b0; stall_left--;
            end else begin
                sym_ready = ($urandom_range(99) < rdy_pct);
            end
            in_valid = (idx < FL) && ($urandom_range(99) < vld_pct);
            in_bit   = in_valid ? b[idx] : 1'($urandom);
            #1;
            if (held) begin
                chk("hold_valid", sym_valid, 1);
                chk("hold_sym", sym, held_sym);
            end
            if (sym_valid && !sym_ready) chk("stall_in_ready", in_ready, 0);
            if (frame_done) begin
                chk("done_sym_valid", sym_valid, 0);
                chk("done_busy", busy, 0);
                chk("done_nsym", nsym, NSYM);
                chk("done_nbits", idx, FL);
                done = 1;
            end else begin
                chk("busy", busy, 1);
            end
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) chk("extra_sym", nsym + 1, NSYM);
                else chk("sym", sym, exp_q.pop_front());
                nsym++;
            end
            held     = sym_valid && !sym_ready;
            held_sym = sym;
            if (in_valid && in_ready) begin
                idx++;
                if (abort_at > 0 && idx == abort_at) aborted = 1;
            end
        end

        if (aborted) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0; sym_ready = 1'b0; rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_sym_valid", sym_valid, 0);
            chk("abort_sym", sym, 0);
            chk("abort_in_ready", in_ready, 0);
            chk("abort_done", frame_done, 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); #1;
                chk("abort_no_done", frame_done, 0);
            end
        end else if (done) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            #1;
            chk("done_pulse_len", frame_done, 0);
        end else begin
            chk("timeout", cyc, 0);
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_sym", sym, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        run_frame(16'h00B4, 100, 100, 0, 0);   // known pattern, sym_ready=1
        run_frame(16'h0001, 100, 100, 0, 0);   // impulse
        run_frame(16'hFFFF, 100, 100, 0, 0);   // all ones
        run_frame(FL'($urandom), 100, 100, 1, 0);  // 5-cycle output stall
        run_frame(FL'($urandom), 100, 100, 0, 10); // reset after bit 10
        for (int f = 0; f < 20; f++) begin
            run_frame(FL'($urandom), 30 + $urandom_range(70), 30 + $urandom_range(70), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_frame_encoder.md
CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 Parameter FRAME_LEN, default 32, is the number of data bits per frame (legal range 1..255).
REQ-002 Parameter G0, default 3'b111, is the generator polynomial for sym[1].
REQ-003 Parameter G1, default 3'b101, is the generator polynomial for sym[0].
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: one-cycle request to begin a frame.
REQ-007 Port in_valid, input, 1 bit: in_bit is valid.
REQ-008 Port in_bit, input, 1 bit: data bit, LSB-first stream order.
REQ-009 Port in_ready, output, 1 bit: the encoder accepts in_bit this cycle.
REQ-010 Port sym_valid, output, 1 bit: sym holds a symbol.
REQ-011 Port sym, output, 2 bits: encoded symbol {G0 output, G1 output}.
REQ-012 Port sym_ready, input, 1 bit: downstream consumes sym this cycle.
REQ-013 Port busy, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse after the last symbol of the frame is consumed.

Function
REQ-015 The FSM SHALL have states IDLE, DATA, TAIL and DRAIN.
REQ-016 IDLE: in_ready=0 and busy=0; start=1 moves to DATA and clears the shift state s[1:0] and the bit counter.
REQ-017 start SHALL be ignored outside IDLE, and in_valid SHALL be ignored in the cycle start is taken.
REQ-018 DATA: in_ready = !sym_valid || sym_ready.
REQ-019 A bit is accepted when in_valid && in_ready.
REQ-020 On acceptance, with r={s[1],s[0],in_bit}, the block SHALL perform all of the following in the same clock edge:
- sym <= {^(r&G0), ^(r&G1)};
- sym_valid <= 1;
- s <= {s[0],in_bit};
- counter <= counter+1.
REQ-021 Latency SHALL be one cycle from acceptance to sym_valid; throughput SHALL be one symbol per cycle while sym_ready=1.
REQ-022 On acceptance of bit FRAME_LEN-1, the FSM SHALL go to TAIL if TAIL_EN is defined, otherwise to DRAIN.
REQ-023 TAIL: in_ready=0; the block SHALL inject in_bit=0 (same encoding as REQ-020) whenever the output slot is free, for exactly 2 bits, then go to DRAIN.
REQ-024 DRAIN: when sym_valid=0 (or sym_ready=1 with no new load), the block SHALL pulse frame_done for 1 cycle and return to IDLE.
REQ-025 sym_valid SHALL clear on sym_ready=1 unless a new symbol is loaded in the same cycle.
REQ-026 While sym_valid && !sym_ready, sym SHALL stay stable and no bit SHALL be accepted.
REQ-027 The counter width SHALL be clog2(FRAME_LEN+1); it SHALL never wrap within a frame.
REQ-028 frame_done SHALL never coincide with sym_valid=1 for that frame.

Reset
REQ-029 rst=1 SHALL force IDLE and set s=0, counter=0, sym=0, sym_valid=0, in_ready=0, busy=0 and frame_done=0 at the next edge.
REQ-030 rst asserted mid-frame SHALL abandon the frame without a frame_done pulse; any pending symbol SHALL be discarded.

Configuration
REQ-031 Macro CONV_TAIL_EN defined: the block SHALL emit FRAME_LEN+2 symbols per frame, and s SHALL be 00 at frame_done.
REQ-032 Macro CONV_TAIL_EN undefined: TAIL SHALL be unreachable, the block SHALL emit FRAME_LEN symbols, and s is unconstrained at frame_done.

Verification
REQ-033 Scenario 1: rst=1 for 3 cycles, then check outputs.
- Required response: all outputs 0 and busy=0.
REQ-034 Scenario 2: start, then bits 0,0,1,0,1,1,0,1 with sym_ready=1.
- Required response: symbols 00,00,11,10,00,01,01,00 in order.
REQ-035 Scenario 3: CONV_TAIL_EN, FRAME_LEN=32, pattern 32'hB4B4B4B4 LSB first.
- Required response: 34 symbols, the last two being 10 then 11, followed by one frame_done pulse.
REQ-036 Scenario 4: sym_ready=0 for 5 cycles after the first symbol.
- Required response: in_ready=0 and sym constant for those cycles; no bit is lost after release.
REQ-037 Scenario 5: start asserted in DATA, then rst asserted after bit 10.
- Required response: start has no effect, no frame_done pulse, and state returns to IDLE with busy=0.
REQ-038 Scenario 6: impulse frame (bit0=1, remaining bits 0).
- Required response: symbols 11,10,11, then 00 for every remaining symbol.
